// File: rtl/serial_wide_adder_pkg.sv
// Shared types and sizing helpers for the chunk-serial wide adder/subtractor.
package serial_add_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int chunks(input int n, input int w);
    return n / w;
  endfunction

  // The chunk index never collapses to zero bits, even for a single chunk.
  function automatic int idx_width(input int c);
    return (c > 1) ? $clog2(c) : 1;
  endfunction

  localparam int DEF_N     = 128;
  localparam int DEF_W     = 32;
  localparam int DEF_IDX_W = idx_width(chunks(DEF_N, DEF_W));

endpackage

// File: rtl/serial_wide_adder_if.sv
// Operand/result bundle for serial_wide_adder; ovf exists only with SERIAL_ADD_OVF_EN.
// valid/ready: a transfer happens on a rising edge where valid and ready are both 1;
// a producer holds valid and its data stable until that edge.
interface serial_wide_adder_if #(
  parameter int N = 128
) ();
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         sub;
  logic         cin;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] sum;
  logic         cout;
`ifdef SERIAL_ADD_OVF_EN
  logic         ovf;
`endif

  modport master (
    output in_valid, a, b, sub, cin, out_ready,
`ifdef SERIAL_ADD_OVF_EN
    input  ovf,
`endif
    input  in_ready, out_valid, sum, cout
  );

  modport slave (
    input  in_valid, a, b, sub, cin, out_ready,
`ifdef SERIAL_ADD_OVF_EN
    output ovf,
`endif
    output in_ready, out_valid, sum, cout
  );
endinterface

// File: rtl/serial_wide_adder_chunk.sv
// Combinational W-bit adder whose carries come from a log-depth Kogge-Stone prefix tree.
module chunk_prefix_adder #(
  parameter int W = 32
) (
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  input  logic         ci,
  output logic [W-1:0] s,
  output logic         co,
  output logic         c_msb_in
);

  logic [W-1:0] p0;
  logic [W-1:0] gg;
  logic [W-1:0] pp;
  logic [W-1:0] gn;
  logic [W-1:0] pn;
  logic [W-1:0] carries;

  // After the tree, gg[i]/pp[i] are the group terms of bits [i:0]; ci folds in last.
  always_comb begin
    p0 = x ^ y;
    gg = x & y;
    pp = p0;
    gn = '0;
    pn = '0;
    for (int d = 1; d < W; d = d * 2) begin
      gn = gg;
      pn = pp;
      for (int i = d; i < W; i++) begin
        gn[i] = gg[i] | (pp[i] & gg[i-d]);
        pn[i] = pp[i] & pp[i-d];
      end
      gg = gn;
      pp = pn;
    end
    carries    = '0;
    carries[0] = ci;
    for (int i = 1; i < W; i++) begin
      carries[i] = gg[i-1] | (pp[i-1] & ci);
    end
    co       = gg[W-1] | (pp[W-1] & ci);
    c_msb_in = carries[W-1];
    s        = p0 ^ carries;
  end

endmodule

// File: rtl/serial_wide_adder.sv
// N-bit add/subtract processed one W-bit chunk per cycle with a registered chunk carry.
// Define SERIAL_ADD_OVF_EN to add the registered signed-overflow output ovf.
module serial_wide_adder
  import serial_add_pkg::*;
#(
  parameter int N = 128,
  parameter int W = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  serial_wide_adder_if.slave bus,
  output state_t             state
);

  localparam int C     = chunks(N, W);
  localparam int IDX_W = idx_width(C);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(C - 1);

  generate
    if (W < 1 || (N % W) != 0) begin : g_bad_width
      $error("serial_wide_adder: N must be a positive multiple of W");
    end
  endgenerate

  logic [N-1:0]     a_q;
  logic [N-1:0]     bx_q;
  logic [N-1:0]     sum_q;
  logic             carry_q;
  logic [IDX_W-1:0] idx;
  logic [W-1:0]     x;
  logic [W-1:0]     y;
  logic [W-1:0]     s;
  logic             co;
  logic             c_msb_in;

  assign x = a_q[int'(idx)*W +: W];
  assign y = bx_q[int'(idx)*W +: W];

  chunk_prefix_adder #(.W(W)) u_chunk (
    .x        (x),
    .y        (y),
    .ci       (carry_q),
    .s        (s),
    .co       (co),
    .c_msb_in (c_msb_in)
  );

  // Subtraction is a + ~b + 1; a borrow-in removes that +1, hence carry = cin ^ sub.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      a_q     <= '0;
      bx_q    <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      idx     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            a_q     <= bus.a;
            bx_q    <= bus.b ^ {N{bus.sub}};
            carry_q <= bus.cin ^ bus.sub;
            idx     <= '0;
            state   <= BUSY;
          end
        end
        BUSY: begin
          sum_q[int'(idx)*W +: W] <= s;
          carry_q                 <= co;
          idx                     <= idx + 1'b1;
          if (idx == LAST) state <= DONE;
        end
        DONE: begin
          if (bus.out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef SERIAL_ADD_OVF_EN
  logic ovf_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
    end else if (state == BUSY && idx == LAST) begin
      ovf_q <= c_msb_in ^ co;
    end
  end

  assign bus.ovf = ovf_q;
`else
  logic unused_msb;
  assign unused_msb = c_msb_in;
`endif

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.sum       = sum_q;
  assign bus.cout      = carry_q;

endmodule

// File: tb/tb_serial_wide_adder.sv
// Directed self-checking bench for serial_wide_adder (N=128, W=32, four chunks).
// Build with SERIAL_ADD_OVF_EN defined to also check the overflow output.
module tb_serial_wide_adder;
  import serial_add_pkg::*;

  localparam int N = 128;
  localparam int W = 32;

  logic   clk;
  logic   rst_n;
  state_t state;
  int     tests;
  int     fails;

  serial_wide_adder_if #(.N(N)) bus ();

  serial_wide_adder #(.N(N), .W(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus),
    .state (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: observed no finish, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Raise in_valid now (called #1 after an edge) and return #1 after the accepting edge.
  task automatic start_op(input logic [N-1:0] a, input logic [N-1:0] b,
                          input logic sub, input logic cin);
    int guard;
    guard = 0;
    while (bus.in_ready !== 1'b1 && guard < 50) begin
      @(posedge clk);
      #1;
      guard++;
    end
    if (guard == 50) check("accept_timeout", {{(N-1){1'b0}}, bus.in_ready}, 1);
    bus.in_valid = 1'b1;
    bus.a        = a;
    bus.b        = b;
    bus.sub      = sub;
    bus.cin      = cin;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.a        = '1;
    bus.b        = '1;
    bus.sub      = ~sub;
    bus.cin      = ~cin;
    check("in_ready_busy", {{(N-1){1'b0}}, bus.in_ready}, 0);
  endtask

  task automatic wait_done(input string tag);
    int lat;
    lat = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      lat++;
      if (bus.out_valid === 1'b1) break;
    end
    check({tag, "_latency"}, N'(lat), 4);
  endtask

  task automatic check_result(input string tag, input logic [N-1:0] exp_sum,
                              input logic exp_cout, input logic exp_ovf);
    check({tag, "_out_valid"}, {{(N-1){1'b0}}, bus.out_valid}, 1);
    check({tag, "_sum"}, bus.sum, exp_sum);
    check({tag, "_cout"}, {{(N-1){1'b0}}, bus.cout}, {{(N-1){1'b0}}, exp_cout});
`ifdef SERIAL_ADD_OVF_EN
    check({tag, "_ovf"}, {{(N-1){1'b0}}, bus.ovf}, {{(N-1){1'b0}}, exp_ovf});
`else
    if (exp_ovf === 1'bx) $display("[TB] unexpected x");
`endif
  endtask

  // Accept the result on the next edge; return #1 after it with in_ready checked.
  task automatic finish_op(input string tag);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    check({tag, "_in_ready_after"}, {{(N-1){1'b0}}, bus.in_ready}, 1);
    check({tag, "_out_valid_after"}, {{(N-1){1'b0}}, bus.out_valid}, 0);
  endtask

  task automatic run_op(input string tag, input logic [N-1:0] a, input logic [N-1:0] b,
                        input logic sub, input logic cin, input logic [N-1:0] exp_sum,
                        input logic exp_cout, input logic exp_ovf);
    start_op(a, b, sub, cin);
    wait_done(tag);
    check_result(tag, exp_sum, exp_cout, exp_ovf);
    finish_op(tag);
  endtask

  initial begin
    tests         = 0;
    fails         = 0;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.sub       = 1'b0;
    bus.cin       = 1'b0;
    bus.out_ready = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", {{(N-1){1'b0}}, bus.in_ready}, 1);
    check("rst_out_valid", {{(N-1){1'b0}}, bus.out_valid}, 0);
    check("rst_sum", bus.sum, 0);
    check("rst_cout", {{(N-1){1'b0}}, bus.cout}, 0);
    check("rst_state", N'(state), N'(IDLE));
`ifdef SERIAL_ADD_OVF_EN
    check("rst_ovf", {{(N-1){1'b0}}, bus.ovf}, 0);
`endif
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    run_op("carry01", 128'h1, 128'hFFFF_FFFF, 1'b0, 1'b0,
           128'h1_0000_0000, 1'b0, 1'b0);
    run_op("ripple", {128{1'b1}}, 128'h1, 1'b0, 1'b0,
           128'h0, 1'b1, 1'b0);
    run_op("sub0m1", 128'h0, 128'h1, 1'b1, 1'b0,
           {128{1'b1}}, 1'b0, 1'b0);
    run_op("sub5m3b", 128'h5, 128'h3, 1'b1, 1'b1,
           128'h1, 1'b1, 1'b0);
    run_op("signovf", {1'b0, {127{1'b1}}}, 128'h1, 1'b0, 1'b0,
           {1'b1, 127'h0}, 1'b0, 1'b1);
    run_op("cin64", 128'hFFFF_FFFF_FFFF_FFFF, 128'h0, 1'b0, 1'b1,
           128'h1_0000_0000_0000_0000, 1'b0, 1'b0);
    run_op("mixed", 128'h8000_0000_0000_0000_0000_0000_0000_0001,
           128'h8000_0000_0000_0000_0000_0000_0000_0001, 1'b0, 1'b0,
           128'h0000_0000_0000_0000_0000_0000_0000_0002, 1'b1, 1'b1);

    // Hold the result for five cycles, then take it and start the next op immediately.
    start_op(128'h1234, 128'h1111, 1'b0, 1'b0);
    wait_done("stall");
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      check_result("stall_hold", 128'h2345, 1'b0, 1'b0);
      check("stall_in_ready", {{(N-1){1'b0}}, bus.in_ready}, 0);
    end
    finish_op("stall");
    run_op("b2b", 128'hFFFF_FFFF_0000_0000, 128'h1_0000_0000, 1'b0, 1'b0,
           128'h1_0000_0000_0000_0000, 1'b0, 1'b0);

    // Reset arrives after two chunks have been written.
    start_op({128{1'b1}}, {128{1'b1}}, 1'b0, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #1;
    check("mid_idx_state", N'(state), N'(BUSY));
    rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", {{(N-1){1'b0}}, bus.out_valid}, 0);
    check("mid_rst_in_ready", {{(N-1){1'b0}}, bus.in_ready}, 1);
    check("mid_rst_sum", bus.sum, 0);
    check("mid_rst_cout", {{(N-1){1'b0}}, bus.cout}, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    run_op("post_rst", 128'hFFFF_FFFF, 128'h1, 1'b0, 1'b0,
           128'h1_0000_0000, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/serial_wide_adder.md
# serial_wide_adder

Multi-cycle wide adder/subtractor that generates per-chunk generate/propagate terms, resolves carries with a prefix carry network, and chains the chunk carry through a register across cycles. It sits in the arithmetic datapath wherever an N-bit add or subtract is too wide for one cycle. It trades throughput for area: one W-bit chunk is processed per cycle behind a valid/ready handshake on each side.

## Interface
- N, 128: total operand width; N % W == 0 required, else elaboration error
- W, 32: chunk width processed per cycle, W >= 1
- clk  in  1  single clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- in_valid  in  1  operand request valid
- in_ready  out  1  block can accept; equals (state == IDLE)
- a  in  N  operand A
- b  in  N  operand B
- sub  in  1  0: a + b + cin; 1: a - b - cin (cin acts as borrow-in)
- cin  in  1  carry-in or borrow-in
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- sum  out  N  result, registered
- cout  out  1  raw carry out of bit N-1 (for sub, 1 = no borrow)
- ovf  out  1  signed overflow; present only with SERIAL_ADD_OVF_EN

## Operation
- C = N/W chunks. States: IDLE, BUSY, DONE.
- IDLE: in_ready=1. When in_valid & in_ready, latch a, b^{N{sub}}, and carry register = cin ^ sub. Clear the chunk index to 0 and go to BUSY.
- BUSY, each edge: chunk k = idx. The chunk sum is a[k] + bx[k] + carry. Write it into sum[k*W +: W], store the chunk carry-out in the carry register, and increment idx. Once chunk C-1 is written, go to DONE.
- DONE: out_valid=1. sum, cout and ovf are held stable until out_ready. On out_valid & out_ready, go to IDLE.
- cout is the final carry register. ovf = carry into bit N-1 XOR carry out of bit N-1, captured on the last chunk.
- Inputs a, b, sub and cin are ignored outside the IDLE acceptance edge.
- No in-flight cancel. in_valid asserted during BUSY or DONE is not accepted and must be held by the producer.

## Timing
- Reset values: state IDLE, in_ready 1, out_valid 0, sum 0, cout 0, ovf 0, carry 0, idx 0. Reset takes effect immediately and asynchronously, including mid-BUSY and mid-DONE. Any partial result is discarded.
- Latency: out_valid rises C edges after the acceptance edge, so C=4 gives 4 cycles and C=1 gives 1 cycle.
- Throughput: one operation per C+2 cycles at best: accept edge, C BUSY edges, then one DONE/out handshake cycle. in_ready returns to 1 the cycle after the output handshake.
- An output handshake and a new input cannot occur in the same cycle, because in_ready=0 in DONE.
- Critical path: one W-bit prefix carry resolution plus a carry-register mux. No combinational path exists from any input to any output except none (in_ready and out_valid are state decodes).

## Configuration
- SERIAL_ADD_OVF_EN defined: the ovf port exists, is computed as above, and is reset to 0.
- Undefined: the ovf port and its capture logic are absent. All other behaviour is identical.

## Structure
- Package serial_add_pkg holds:
  - state enum (IDLE, BUSY, DONE)
  - function chunks(N, W)
  - localparam for the index width, $clog2(C) with a minimum of 1
- Sub-module chunk_prefix_adder is combinational and W bits wide. It takes x, y and ci, and outputs s, co and c_msb_in (carry into the chunk MSB).
  - Internals: g = x&y and p = x^y, a log-depth prefix carry network, then s = p ^ carries.
  - It is instantiated once and time-multiplexed across chunks.

## Test plan
- N=128, W=32, a=1, b=0xFFFF_FFFF, sub=0, cin=0 -> sum=0x1_0000_0000, cout=0; verifies the carry crossing chunk 0 to 1, with out_valid exactly 4 cycles after accept.
- a=all ones, b=1, sub=0, cin=0 -> sum=0, cout=1, ovf=0; verifies the carry rippling through all 4 chunks.
- a=0, b=1, sub=1, cin=0 -> sum=all ones, cout=0, ovf=0. Then a=5, b=3, sub=1, cin=1 -> sum=1, cout=1.
- a=0x7FFF...FFFF, b=1, sub=0 -> sum=0x8000...0000, cout=0, ovf=1 (only with SERIAL_ADD_OVF_EN; without it, build the bench without the port).
- Backpressure: out_ready=0 for 5 cycles in DONE -> out_valid, sum and cout stable, and in_ready=0 throughout. Then out_ready=1 -> in_ready=1 on the next cycle, and back-to-back in_valid is accepted there.
- Reset mid-op: drop rst_n for one cycle during BUSY idx=2 -> out_valid=0, sum=0 and in_ready=1 immediately. The next op 0xFFFF_FFFF+1 yields 0x1_0000_0000, with no stale carry.
